// File: rtl/calendar_key_ctrl.sv
// calendar_key_ctrl
// Front-panel key controller for the calendar. Synchronizes and debounces
// the select/up/down push-buttons, tracks the edited field and produces
// one-hot increment/decrement pulses with hold-to-auto-repeat.
//
// Ports:
//   Clk        - system clock
//   Reset      - asynchronous active-high reset
//   set_en     - 1 = adjust mode enabled
//   key_sel    - raw select key (1 = pressed), rotates edited field
//   key_up     - raw up key (1 = pressed)
//   key_down   - raw down key (1 = pressed)
//   cnt_inc    - one-hot increment pulse (bit0 day, bit1 month, bit2 year)
//   cnt_dec    - one-hot decrement pulse, same encoding
//   field_sel  - one-hot edited field, 000 while set_en = 0
module calendar_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 10_000_000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       set_en,
    input  logic       key_sel,
    input  logic       key_up,
    input  logic       key_down,
    output logic [2:0] cnt_inc,
    output logic [2:0] cnt_dec,
    output logic [2:0] field_sel
);

    localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RD_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RP_LAST  = RW'(REPEAT_PERIOD - 1);

    // key index: 0 = select, 1 = up, 2 = down
    localparam int K_SEL  = 0;
    localparam int K_UP   = 1;
    localparam int K_DOWN = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RPT  = 2'd2
    } state_t;

    logic [2:0]    raw_s;
    logic [2:0]    sync1_r;
    logic [2:0]    sync2_r;
    logic [2:0]    db_r;
    logic [2:0]    db_d_r;
    logic [2:0]    press_r;
    logic [2:0]    rise_s;
    logic [DW-1:0] dbcnt_r [3];
    logic [2:0]    fld_r;

    state_t        state_r, state_s;
    logic          dir_r, dir_s;       // 1 = up, 0 = down
    logic [RW-1:0] rcnt_r, rcnt_s;
    logic          pulse_s;
    logic          dir_held_s;
    logic          opp_rise_s;
    logic          exit_s;
    logic [2:0]    inc_r;
    logic [2:0]    dec_r;

    assign raw_s  = {key_down, key_up, key_sel};
    assign rise_s = db_r & ~db_d_r;

    // Two-flop synchronizer for the asynchronous raw keys
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
        end
    end

    // Per-key debouncer: accept a new level after DEBOUNCE_CYCLES differing cycles
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            db_r <= 3'b000;
            for (int k = 0; k < 3; k++) begin
                dbcnt_r[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (sync2_r[k] == db_r[k]) begin
                    dbcnt_r[k] <= '0;
                end else if (dbcnt_r[k] == DB_LAST) begin
                    db_r[k]    <= sync2_r[k];
                    dbcnt_r[k] <= '0;
                end else begin
                    dbcnt_r[k] <= dbcnt_r[k] + DW'(1);
                end
            end
        end
    end

    // Delayed debounced state and registered press (rising-edge) strobes
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            db_d_r  <= 3'b000;
            press_r <= 3'b000;
        end else begin
            db_d_r  <= db_r;
            press_r <= rise_s;
        end
    end

    // Edited-field rotation; value is kept while adjust mode is off
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            fld_r <= 3'b001;
        end else if (press_r[K_SEL] && set_en) begin
            fld_r <= {fld_r[1:0], fld_r[2]};
        end else begin
            fld_r <= fld_r;
        end
    end

    assign field_sel = set_en ? fld_r : 3'b000;

    // Abort conditions for an active hold: key released, other key pressed,
    // adjust mode left, or field changed
    always_comb begin
        dir_held_s = dir_r ? db_r[K_UP] : db_r[K_DOWN];
        opp_rise_s = dir_r ? rise_s[K_DOWN] : rise_s[K_UP];
        exit_s     = !set_en || press_r[K_SEL] || !dir_held_s || opp_rise_s;
    end

    // Repeat FSM next-state and pulse request
    always_comb begin
        state_s = state_r;
        dir_s   = dir_r;
        rcnt_s  = rcnt_r;
        pulse_s = 1'b0;
        case (state_r)
            IDLE: begin
                // A lone press edge with exactly one of up/down held starts a hold;
                // a select press in the same cycle takes priority
                if (set_en && !press_r[K_SEL] &&
                    (press_r[K_UP] ^ press_r[K_DOWN]) &&
                    (db_r[K_UP] ^ db_r[K_DOWN])) begin
                    pulse_s = 1'b1;
                    dir_s   = press_r[K_UP];
                    rcnt_s  = '0;
                    state_s = HOLD;
                end else begin
                    state_s = IDLE;
                end
            end
            HOLD: begin
                if (exit_s) begin
                    rcnt_s  = '0;
                    state_s = IDLE;
                end else if (rcnt_r == RD_LAST) begin
                    pulse_s = 1'b1;
                    rcnt_s  = '0;
                    state_s = RPT;
                end else begin
                    rcnt_s  = rcnt_r + RW'(1);
                end
            end
            RPT: begin
                if (exit_s) begin
                    rcnt_s  = '0;
                    state_s = IDLE;
                end else if (rcnt_r == RP_LAST) begin
                    pulse_s = 1'b1;
                    rcnt_s  = '0;
                end else begin
                    rcnt_s  = rcnt_r + RW'(1);
                end
            end
            default: begin
                rcnt_s  = '0;
                state_s = IDLE;
            end
        endcase
    end

    // Repeat FSM state and registered pulse outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
            dir_r   <= 1'b0;
            rcnt_r  <= '0;
            inc_r   <= 3'b000;
            dec_r   <= 3'b000;
        end else begin
            state_r <= state_s;
            dir_r   <= dir_s;
            rcnt_r  <= rcnt_s;
            inc_r   <= (pulse_s && dir_s)  ? fld_r : 3'b000;
            dec_r   <= (pulse_s && !dir_s) ? fld_r : 3'b000;
        end
    end

    assign cnt_inc = inc_r;
    assign cnt_dec = dec_r;

endmodule

// File: tb/tb_calendar_key_ctrl.sv
module tb_calendar_key_ctrl;

    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 5;
    localparam int LAT = DB + 4; // drive-cycle to output-cycle latency of a clean press

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       set_en = 1'b0;
    logic       key_sel = 1'b0;
    logic       key_up = 1'b0;
    logic       key_down = 1'b0;
    logic [2:0] cnt_inc;
    logic [2:0] cnt_dec;
    logic [2:0] field_sel;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         c;
        logic [2:0] inc;
        logic [2:0] dec;
    } ev_t;

    ev_t ev_q[$];

    calendar_key_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .set_en   (set_en),
        .key_sel  (key_sel),
        .key_up   (key_up),
        .key_down (key_down),
        .cnt_inc  (cnt_inc),
        .cnt_dec  (cnt_dec),
        .field_sel(field_sel)
    );

    always #10 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // record every cycle with a nonzero pulse output
    always @(negedge Clk) begin
        if (cnt_inc !== 3'b000 || cnt_dec !== 3'b000) begin
            ev_q.push_back('{cyc, cnt_inc, cnt_dec});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        wait_cyc(3);
        n_tests++;
        if (cnt_inc !== 3'b000) begin
            n_fail++; $display("FAIL reset_inc: got %b want 000", cnt_inc);
        end
        n_tests++;
        if (cnt_dec !== 3'b000) begin
            n_fail++; $display("FAIL reset_dec: got %b want 000", cnt_dec);
        end
        n_tests++;
        if (field_sel !== 3'b000) begin
            n_fail++; $display("FAIL reset_field_sel: got %b want 000", field_sel);
        end
        Reset = 1'b0;
        wait_cyc(2);
        set_en = 1'b1;
        wait_cyc(1);
        n_tests++;
        if (field_sel !== 3'b001) begin
            n_fail++; $display("FAIL reset_fld_enabled: got %b want 001", field_sel);
        end
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL reset_no_pulse: got %0d pulses want 0", ev_q.size());
        end
    endtask

    task automatic test_short_press;
        ev_q.delete();
        key_up = 1'b1;
        wait_cyc(3);
        key_up = 1'b0;
        wait_cyc(30);
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL short_press: got %0d pulses want 0", ev_q.size());
        end
    endtask

    task automatic test_hold_repeat;
        int t0;
        int offs[5] = '{0, 20, 25, 30, 35};
        ev_q.delete();
        key_up = 1'b1;
        t0 = cyc + LAT;
        wait_cyc(40);
        key_up = 1'b0;
        wait_cyc(30);
        n_tests++;
        if (ev_q.size() != 5) begin
            n_fail++; $display("FAIL hold_count: got %0d pulses want 5", ev_q.size());
        end
        for (int i = 0; i < 5 && i < ev_q.size(); i++) begin
            n_tests++;
            if (ev_q[i].c != t0 + offs[i] || ev_q[i].inc !== 3'b001 || ev_q[i].dec !== 3'b000) begin
                n_fail++;
                $display("FAIL hold_pulse%0d: got cyc %0d inc %b dec %b want cyc %0d inc 001 dec 000",
                         i, ev_q[i].c, ev_q[i].inc, ev_q[i].dec, t0 + offs[i]);
            end
        end
    endtask

    task automatic test_field_sel;
        logic [2:0] exp_fs[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        int k;
        n_tests++;
        if (field_sel !== 3'b001) begin
            n_fail++; $display("FAIL fs_start: got %b want 001", field_sel);
        end
        for (int i = 1; i < 6; i++) begin
            key_sel = 1'b1;
            wait_cyc(LAT - 1);
            n_tests++;
            if (field_sel !== exp_fs[i-1]) begin
                n_fail++; $display("FAIL fs_before%0d: got %b want %b", i, field_sel, exp_fs[i-1]);
            end
            wait_cyc(1);
            n_tests++;
            if (field_sel !== exp_fs[i]) begin
                n_fail++; $display("FAIL fs_after%0d: got %b want %b", i, field_sel, exp_fs[i]);
            end
            wait_cyc(2);
            key_sel = 1'b0;
            wait_cyc(10);
        end
        ev_q.delete();
        k = cyc;
        key_down = 1'b1;
        wait_cyc(10);
        key_down = 1'b0;
        wait_cyc(15);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL down_count: got %0d pulses want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].c != k + LAT || ev_q[0].dec !== 3'b100 || ev_q[0].inc !== 3'b000) begin
                n_fail++;
                $display("FAIL down_pulse: got cyc %0d inc %b dec %b want cyc %0d inc 000 dec 100",
                         ev_q[0].c, ev_q[0].inc, ev_q[0].dec, k + LAT);
            end
        end
        key_sel = 1'b1;
        wait_cyc(10);
        key_sel = 1'b0;
        wait_cyc(10);
        n_tests++;
        if (field_sel !== 3'b001) begin
            n_fail++; $display("FAIL fs_wrap: got %b want 001", field_sel);
        end
    endtask

    task automatic test_glitch;
        int last;
        ev_q.delete();
        last = 0;
        for (int i = 0; i < 15; i++) begin
            key_up = ~key_up;
            last = cyc;
            wait_cyc(2);
        end
        wait_cyc(10);
        key_up = 1'b0;
        wait_cyc(20);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL glitch_count: got %0d pulses want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].c != last + LAT || ev_q[0].inc !== 3'b001) begin
                n_fail++;
                $display("FAIL glitch_pulse: got cyc %0d inc %b want cyc %0d inc 001",
                         ev_q[0].c, ev_q[0].inc, last + LAT);
            end
        end
    endtask

    task automatic test_both;
        ev_q.delete();
        key_up = 1'b1;
        key_down = 1'b1;
        wait_cyc(10);
        key_down = 1'b0;
        wait_cyc(40);
        key_up = 1'b0;
        wait_cyc(15);
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL both_keys: got %0d pulses want 0", ev_q.size());
        end
    endtask

    task automatic test_set_en_off;
        int t0;
        set_en = 1'b0;
        ev_q.delete();
        key_up = 1'b1;
        wait_cyc(50);
        n_tests++;
        if (field_sel !== 3'b000) begin
            n_fail++; $display("FAIL off_field_sel: got %b want 000", field_sel);
        end
        wait_cyc(50);
        key_up = 1'b0;
        wait_cyc(15);
        n_tests++;
        if (ev_q.size() != 0) begin
            n_fail++; $display("FAIL off_no_pulse: got %0d pulses want 0", ev_q.size());
        end
        set_en = 1'b1;
        wait_cyc(2);
        ev_q.delete();
        t0 = cyc + LAT;
        key_up = 1'b1;
        wait_cyc(30);
        set_en = 1'b0;
        wait_cyc(20);
        key_up = 1'b0;
        wait_cyc(15);
        set_en = 1'b1;
        wait_cyc(2);
        n_tests++;
        if (ev_q.size() != 2) begin
            n_fail++; $display("FAIL off_rpt_count: got %0d pulses want 2", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].c != t0 || ev_q[1].c != t0 + RD) begin
                n_fail++;
                $display("FAIL off_rpt_times: got %0d,%0d want %0d,%0d",
                         ev_q[0].c, ev_q[1].c, t0, t0 + RD);
            end
        end
    endtask

    task automatic test_reset_mid;
        int r;
        ev_q.delete();
        key_up = 1'b1;
        wait_cyc(LAT + RD + RP);
        n_tests++;
        if (cnt_inc !== 3'b001) begin
            n_fail++; $display("FAIL mid_rpt_pulse: got %b want 001", cnt_inc);
        end
        Reset = 1'b1;
        #1;
        n_tests++;
        if (cnt_inc !== 3'b000 || cnt_dec !== 3'b000) begin
            n_fail++; $display("FAIL mid_reset_out: got inc %b dec %b want 000 000", cnt_inc, cnt_dec);
        end
        n_tests++;
        if (field_sel !== 3'b001) begin
            n_fail++; $display("FAIL mid_reset_fs: got %b want 001", field_sel);
        end
        wait_cyc(2);
        Reset = 1'b0;
        r = cyc;
        ev_q.delete();
        wait_cyc(14);
        key_up = 1'b0;
        wait_cyc(15);
        n_tests++;
        if (ev_q.size() != 1) begin
            n_fail++; $display("FAIL mid_after_count: got %0d pulses want 1", ev_q.size());
        end else begin
            n_tests++;
            if (ev_q[0].c != r + LAT || ev_q[0].inc !== 3'b001) begin
                n_fail++;
                $display("FAIL mid_after_pulse: got cyc %0d inc %b want cyc %0d inc 001",
                         ev_q[0].c, ev_q[0].inc, r + LAT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_hold_repeat();
        test_field_sel();
        test_glitch();
        test_both();
        test_set_en_off();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
